wb_b3_burst_master: RTL and testbench
=====================================

# wb_b3_burst_master

Wishbone B3 initiator that turns a simple command plus data stream into registered-feedback bursts. A bus client issues a command with start address, beat count, direction and burst type. The block drives CTI/BTE-tagged cycles toward a B3 responder such as the on-chip RAM, returning read data or consuming write data beat by beat. It sits between DMA/loader logic and the Wishbone interconnect.

## Interface
Parameters:
- `aw`, 32, address width; data width is fixed at 32 and `wb_sel_o` is always 4'hf.
- `len_w`, 8, width of `cmd_len_i`; encodes beats-1, giving 1..2^len_w beats.

Ports:
- `wb_clk_i`  in  1  single clock, all state on rising edge.
- `wb_rst_i`  in  1  synchronous, active-high reset.
- `cmd_valid_i` in 1 / `cmd_ready_o` out 1: command handshake; accepted when both are high.
- `cmd_adr_i`  in  aw  byte start address; bits [1:0] ignored and driven 0.
- `cmd_len_i`  in  len_w  beats minus one.
- `cmd_we_i`  in  1  1 = write burst, 0 = read burst.
- `cmd_bte_i`  in  2  00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16.
- `wr_data_i` in 32 / `wr_valid_i` in 1 / `wr_ready_o` out 1: write data stream.
- `rd_data_o` out 32 / `rd_valid_o` out 1: read data, no backpressure.
- `done_o`  out  1  one-cycle pulse at command completion.
- `err_o`  out  1  qualifies `done_o`: command terminated by `wb_err_i`/`wb_rty_i`.
- Wishbone outputs: `wb_adr_o[aw]`, `wb_dat_o[32]`, `wb_sel_o[4]`, `wb_we_o`, `wb_bte_o[2]`, `wb_cti_o[3]`, `wb_cyc_o`, `wb_stb_o`.
- Wishbone inputs: `wb_dat_i[32]`, `wb_ack_i`, `wb_err_i`, `wb_rty_i`.

## Operation
- FSM states:
  - IDLE: `cmd_ready_o`=1.
  - BUS: `cyc_o`=1.
  - DONE: one cycle; `done_o` pulses, then back to IDLE.
- IDLE→BUS on command accept. BUS→DONE when the last beat is acked, or on `wb_err_i`/`wb_rty_i` (`rty` treated as error, no retry).
- Command latches address, remaining-beat counter, direction and BTE. `wb_bte_o` holds the latched BTE for the whole cycle.
- `wb_cti_o` is 3'b010 while remaining>1 and 3'b111 on the last beat; a single-beat command uses 3'b111 only.
- Address advances on each ack by one word:
  - linear: full word address +1, wrapping modulo 2^aw.
  - wrap-N: only the low log2(N) word-address bits increment; upper bits are held.
- Read: `stb_o`=1 throughout BUS. Each ack captures `wb_dat_i` into `rd_data_o`, with `rd_valid_o`=1 the following cycle.
- Write: a one-entry holding register feeds `wb_dat_o`.
  - `stb_o`=holding-valid.
  - `wr_ready_o` = BUS & write & (unloaded beats > 0) & (!holding-valid | `wb_ack_i`).
  - An empty holding register drops `stb_o` mid-burst while `cyc_o` stays high.
- Error: `cyc_o`/`stb_o` go low on the next edge; remaining beats are discarded; an unconsumed write beat is discarded; `done_o`=`err_o`=1 in DONE.
- Reset (any time, including mid-burst) → IDLE next edge, with no `done_o`.

## Timing
- Reset values: `cyc_o`, `stb_o`, `we_o`, `adr_o`, `cti_o`, `bte_o`, `dat_o`, `rd_valid_o`, `rd_data_o`, `done_o`, `err_o`, `wr_ready_o` = 0; `sel_o`=4'hf; `cmd_ready_o`=1 from the first cycle in IDLE.
- Command accepted at edge T: `cyc_o`/`stb_o` (read) high in cycle T+1.
- Against a registered-ack responder:
  - first ack in T+2, then one ack per cycle.
  - N-beat read: `rd_valid_o` in T+3..T+N+2.
  - `done_o` in T+N+2, coincident with the last `rd_valid_o`.
- `cyc_o` falls the cycle after the last ack. `cmd_ready_o` returns the cycle after `done_o`.
- Only one command is in flight at a time; `cmd_valid_i` during BUS/DONE is ignored.
- `wr_ready_o` depends combinationally on `wb_ack_i` so that back-to-back write beats sustain one per cycle.

## Structure
- Package `wb_b3_pkg` holds:
  - CTI constants: CLASSIC 3'b000, CONST 3'b001, INC 3'b010, EOB 3'b111.
  - BTE constants: LINEAR, WRAP4, WRAP8, WRAP16.
  - The FSM state enum.
- Sub-module `wb_b3_adr_gen`: combinational next-word-address from current address and BTE. The RAM slave's burst logic can share it later.

## Test plan
- Single read, len 0 at 0x100 (RAM word 0xDEADBEEF) → one cycle with `cti_o`=111; `rd_data_o`=0xDEADBEEF; `done_o`=1, `err_o`=0.
- 4-beat linear read from 0x40 (preloaded 0x11,0x22,0x33,0x44) → `adr_o` 0x40,0x44,0x48,0x4C; `cti_o` 010,010,010,111; `rd_valid_o` on four consecutive cycles.
- Wrap-4 write of 0xA0..0xA3 from 0x18 → `adr_o` 0x18,0x1C,0x10,0x14; RAM read-back matches.
- 8-beat write with `wr_valid_i` low for 3 cycles after beat 2 → `stb_o` low for those cycles while `cyc_o` stays 1; all 8 words written in order.
- `wb_err_i` on beat 3 of 8 → `cyc_o`=0 next cycle; `done_o`=`err_o`=1; `cmd_ready_o`=1 the cycle after.
- `wb_rst_i` during beat 2 of a 16-beat read → all outputs at reset values next cycle; no `done_o`; a fresh command then runs correctly.

Source files
------------

// File: rtl/wb_b3_burst_master_pkg.sv
// Shared Wishbone B3 constants and the burst master FSM encoding.
// The cycle-type and burst-type codes are used by both initiator and responder logic.
package wb_b3_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/wb_b3_burst_master_if.sv
// Wishbone B3 bus bundle between the burst master and a responder.
// Signal names keep the initiator-side _o/_i suffixes used on the bus.
interface wb_b3_burst_master_if #(
  parameter int aw = 32
);
  logic [aw-1:0] wb_adr_o;
  logic [31:0]   wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic          wb_we_o;
  logic [1:0]    wb_bte_o;
  logic [2:0]    wb_cti_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic [31:0]   wb_dat_i;
  logic          wb_ack_i;
  logic          wb_err_i;
  logic          wb_rty_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_bte_o, wb_cti_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_bte_o, wb_cti_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );
endinterface

// File: rtl/wb_b3_burst_master_adr_gen.sv
// Next word address for a Wishbone B3 incrementing burst, honouring the BTE wrap size.
// Works on word addresses so that byte-offset bits never enter the arithmetic.
module wb_b3_adr_gen
  import wb_b3_pkg::*;
#(
  parameter int aw = 32
) (
  input  logic [aw-3:0] word,
  input  logic [1:0]    bte,
  output logic [aw-3:0] next_word
);

  logic [aw-3:0] inc;
  logic [aw-3:0] mask;

  always_comb begin
    inc = word + (aw-2)'(1);
    // Only the bits under the mask advance; bits above are held for wrapping bursts.
    case (bte)
      BTE_WRAP4:  mask = (aw-2)'(3);
      BTE_WRAP8:  mask = (aw-2)'(7);
      BTE_WRAP16: mask = (aw-2)'(15);
      default:    mask = '1;
    endcase
    next_word = (word & ~mask) | (inc & mask);
  end

endmodule

// File: rtl/wb_b3_burst_master.sv
// Wishbone B3 burst initiator: one command in, one CTI/BTE-tagged registered-feedback cycle out.
// Read data streams out without backpressure; write data passes through a one-entry holding register.
module wb_b3_burst_master
  import wb_b3_pkg::*;
#(
  parameter int aw    = 32,
  parameter int len_w = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  // Handshakes (cmd, wr): a transfer occurs on a rising edge where valid and ready are both
  // high; valid never waits on ready, ready may depend combinationally on bus state.
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [aw-1:0]        cmd_adr_i,
  input  logic [len_w-1:0]     cmd_len_i,
  input  logic                 cmd_we_i,
  input  logic [1:0]           cmd_bte_i,
  input  logic [31:0]          wr_data_i,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  output logic [31:0]          rd_data_o,
  output logic                 rd_valid_o,
  output logic                 done_o,
  output logic                 err_o,
  wb_b3_burst_master_if.master wb,
  output state_e               dbg_state
);

  typedef logic [len_w:0] cnt_t;
  localparam cnt_t ONE = cnt_t'(1);

  state_e        state;
  logic [aw-3:0] adr_w;
  logic [aw-3:0] adr_w_next;
  cnt_t          remaining;
  cnt_t          unloaded;
  logic          we;
  logic [1:0]    bte;
  logic          hold_valid;
  logic [31:0]   hold;
  logic          err_q;
  logic          ack;
  logic          term;
  logic          wr_fire;
  logic          cmd_fire;
  logic          unused_adr_bits;

  // Byte-offset bits of the command address are dropped; the bus only sees word addresses.
  assign unused_adr_bits = ^cmd_adr_i[1:0];

  wb_b3_adr_gen #(.aw(aw)) u_adr_gen (
    .word      (adr_w),
    .bte       (bte),
    .next_word (adr_w_next)
  );

  assign cmd_ready_o = (state == ST_IDLE);
  assign cmd_fire    = cmd_valid_i & cmd_ready_o;

  assign wb.wb_cyc_o = (state == ST_BUS);
  assign wb.wb_stb_o = wb.wb_cyc_o & (!we | hold_valid);
  assign wb.wb_adr_o = {adr_w, 2'b00};
  assign wb.wb_dat_o = hold;
  assign wb.wb_sel_o = 4'hf;
  assign wb.wb_we_o  = we;
  assign wb.wb_bte_o = bte;
  assign wb.wb_cti_o = !wb.wb_cyc_o      ? CTI_CLASSIC :
                       (remaining > ONE) ? CTI_INC     : CTI_EOB;

  // A registered-feedback slave may still hold ack after stb drops; only strobed acks count.
  assign ack  = wb.wb_stb_o & wb.wb_ack_i;
  assign term = wb.wb_stb_o & (wb.wb_err_i | wb.wb_rty_i);

  // The holding register can refill in the same cycle its beat is acked, sustaining one beat per clock.
  assign wr_ready_o = wb.wb_cyc_o & we & (unloaded != '0) & (!hold_valid | ack);
  assign wr_fire    = wr_ready_o & wr_valid_i;

  assign done_o    = (state == ST_DONE);
  assign err_o     = done_o & err_q;
  assign dbg_state = state;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= ST_IDLE;
      adr_w      <= '0;
      remaining  <= '0;
      unloaded   <= '0;
      we         <= 1'b0;
      bte        <= '0;
      hold_valid <= 1'b0;
      hold       <= '0;
      err_q      <= 1'b0;
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
    end else begin
      rd_valid_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            state      <= ST_BUS;
            adr_w      <= cmd_adr_i[aw-1:2];
            remaining  <= cnt_t'(cmd_len_i) + ONE;
            unloaded   <= cnt_t'(cmd_len_i) + ONE;
            we         <= cmd_we_i;
            bte        <= cmd_bte_i;
            hold_valid <= 1'b0;
            err_q      <= 1'b0;
          end
        end
        ST_BUS: begin
          if (wr_fire) begin
            hold       <= wr_data_i;
            hold_valid <= 1'b1;
            unloaded   <= unloaded - ONE;
          end else if (ack) begin
            hold_valid <= 1'b0;
          end
          if (!we && ack) begin
            rd_data_o  <= wb.wb_dat_i;
            rd_valid_o <= 1'b1;
          end
          // Error and retry both end the command; pending beats and any held write word are dropped.
          if (term) begin
            err_q      <= 1'b1;
            hold_valid <= 1'b0;
            state      <= ST_DONE;
          end else if (ack) begin
            adr_w     <= adr_w_next;
            remaining <= remaining - ONE;
            if (remaining == ONE) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_b3_burst_master.sv
// Directed bench for wb_b3_burst_master against a registered-feedback Wishbone B3 RAM model.
// Expected addresses, data and cycle numbers are hand-derived in each step.
module tb_wb_b3_burst_master;
  import wb_b3_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_adr = '0;
  logic [7:0]  cmd_len = '0;
  logic        cmd_we = 1'b0;
  logic [1:0]  cmd_bte = '0;
  logic [31:0] wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic        err;
  state_e      dbg_state;

  wb_b3_burst_master_if #(.aw(32)) wb ();

  wb_b3_burst_master #(.aw(32), .len_w(8)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_adr_i   (cmd_adr),
    .cmd_len_i   (cmd_len),
    .cmd_we_i    (cmd_we),
    .cmd_bte_i   (cmd_bte),
    .wr_data_i   (wr_data),
    .wr_valid_i  (wr_valid),
    .wr_ready_o  (wr_ready),
    .rd_data_o   (rd_data),
    .rd_valid_o  (rd_valid),
    .done_o      (done),
    .err_o       (err),
    .wb          (wb.master),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset bookkeeping ----------------
  initial forever #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // ---------------- registered-feedback RAM responder ----------------
  logic [31:0] mem [0:127];
  logic        s_ack;
  logic        s_err;
  logic [31:0] s_dat;
  int          s_beat;
  int          err_beat = 255;
  logic [31:0] s_rd_adr;

  function automatic logic [31:0] tb_next(input logic [31:0] a, input logic [1:0] b);
    logic [31:0] w;
    w = a >> 2;
    case (b)
      2'b00:   w = w + 32'd1;
      2'b01:   w = {w[31:2], w[1:0] + 2'd1};
      2'b10:   w = {w[31:3], w[2:0] + 3'd1};
      default: w = {w[31:4], w[3:0] + 4'd1};
    endcase
    return {w[29:0], 2'b00};
  endfunction

  assign s_rd_adr    = s_ack ? tb_next(wb.wb_adr_o, wb.wb_bte_o) : wb.wb_adr_o;
  assign wb.wb_ack_i = s_ack;
  assign wb.wb_err_i = s_err;
  assign wb.wb_rty_i = 1'b0;
  assign wb.wb_dat_i = s_dat;

  always @(posedge clk) begin
    if (rst) begin
      s_ack  <= 1'b0;
      s_err  <= 1'b0;
      s_beat <= 0;
      s_dat  <= '0;
      for (int i = 0; i < 128; i++) mem[i] <= {16'hC0DE, 16'(i)};
      mem[64] <= 32'hDEADBEEF;
      mem[16] <= 32'h11;
      mem[17] <= 32'h22;
      mem[18] <= 32'h33;
      mem[19] <= 32'h44;
    end else begin
      if (wb.wb_cyc_o && wb.wb_stb_o && s_ack && wb.wb_we_o) mem[wb.wb_adr_o[8:2]] <= wb.wb_dat_o;
      if (!wb.wb_cyc_o) begin
        s_ack  <= 1'b0;
        s_err  <= 1'b0;
        s_beat <= 0;
      end else begin
        if (s_ack && wb.wb_stb_o) s_beat <= s_beat + 1;
        if (wb.wb_stb_o && !s_err && !(s_ack && wb.wb_cti_o == 3'b111)) begin
          if (s_beat + (s_ack ? 1 : 0) == err_beat) begin
            s_err <= 1'b1;
            s_ack <= 1'b0;
          end else begin
            s_ack <= 1'b1;
            s_dat <= mem[s_rd_adr[8:2]];
          end
        end else begin
          s_ack <= 1'b0;
          s_err <= 1'b0;
        end
      end
    end
  end

  // ---------------- bus monitor ----------------
  logic [31:0] adr_q[$];
  logic [31:0] cti_q[$];
  logic [31:0] wdat_q[$];
  logic [31:0] rd_q[$];
  int          rdcyc_q[$];
  int          gap_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (wb.wb_cyc_o && wb.wb_stb_o && wb.wb_ack_i) begin
        adr_q.push_back(wb.wb_adr_o);
        cti_q.push_back(32'(wb.wb_cti_o));
        if (wb.wb_we_o) wdat_q.push_back(wb.wb_dat_o);
      end
      if (rd_valid) begin
        rd_q.push_back(rd_data);
        rdcyc_q.push_back(cyc_n);
      end
      if (wb.wb_cyc_o && !wb.wb_stb_o) gap_cnt <= gap_cnt + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drain(input string tag);
    logic [31:0] o;
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      o = (i < obs_q.size()) ? obs_q[i] : 32'hxxxx_xxxx;
      chk($sformatf("%s[%0d]", tag, i), o, exp_q[i]);
    end
    exp_q.delete();
  endtask

  task automatic clear_mon();
    adr_q.delete();
    cti_q.delete();
    wdat_q.delete();
    rd_q.delete();
    rdcyc_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  int   t_acc;
  int   done_cyc;
  logic done_seen;
  logic done_err;
  logic done_cyc_o;
  logic done_rdy;

  task automatic issue(input logic [31:0] a, input logic [7:0] l, input logic w, input logic [1:0] b);
    int g = 0;
    @(negedge clk);
    cmd_adr = a; cmd_len = l; cmd_we = w; cmd_bte = b; cmd_valid = 1'b1;
    while (!cmd_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("cmd_accept_wait", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    t_acc = cyc_n;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int g = 0;
    done_seen = 1'b0;
    while (g < 200) begin
      @(negedge clk);
      g++;
      if (done) begin
        done_seen  = 1'b1;
        done_cyc   = cyc_n;
        done_err   = err;
        done_cyc_o = wb.wb_cyc_o;
        done_rdy   = cmd_ready;
        break;
      end
    end
    chk({tag, "_done_seen"}, 32'(done_seen), 32'd1);
    #1;
  endtask

  task automatic feed(input int n, input logic [31:0] base, input int gap_after, input int gap_len);
    int i = 0;
    int g = 0;
    int guard = 0;
    while (i < n && guard < 300) begin
      @(negedge clk);
      guard++;
      if (i == gap_after && g < gap_len) begin
        wr_valid = 1'b0;
        g++;
      end else begin
        wr_valid = 1'b1;
        wr_data  = base + 32'(i);
        if (wr_ready) i++;
      end
    end
    @(negedge clk);
    wr_valid = 1'b0;
    chk("feed_all_loaded", 32'(i), 32'(n));
  endtask

  // ---------------- directed sequence ----------------
  int g0;
  int dsum;

  initial begin
    // Reset values, sampled while reset is still applied.
    repeat (2) @(negedge clk);
    chk("rst_cyc", 32'(wb.wb_cyc_o), 0);
    chk("rst_stb", 32'(wb.wb_stb_o), 0);
    chk("rst_we", 32'(wb.wb_we_o), 0);
    chk("rst_adr", wb.wb_adr_o, 0);
    chk("rst_cti", 32'(wb.wb_cti_o), 0);
    chk("rst_bte", 32'(wb.wb_bte_o), 0);
    chk("rst_dat", wb.wb_dat_o, 0);
    chk("rst_sel", 32'(wb.wb_sel_o), 32'hf);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    rst = 1'b0;

    // Single-beat read at 0x100.
    clear_mon();
    issue(32'h100, 8'd0, 1'b0, 2'b00);
    @(negedge clk);
    chk("t1_cyc_T1", 32'(wb.wb_cyc_o), 1);
    chk("t1_stb_T1", 32'(wb.wb_stb_o), 1);
    wait_done("t1");
    chk("t1_done_cycle", 32'(done_cyc), 32'(t_acc + 2));
    chk("t1_err", 32'(done_err), 0);
    obs_q = adr_q; exp_q.push_back(32'h100); drain("t1_adr");
    obs_q = cti_q; exp_q.push_back(32'h7); drain("t1_cti");
    obs_q = rd_q; exp_q.push_back(32'hDEADBEEF); drain("t1_rd");

    // 4-beat linear read from 0x40.
    clear_mon();
    issue(32'h40, 8'd3, 1'b0, 2'b00);
    wait_done("t2");
    chk("t2_done_cycle", 32'(done_cyc), 32'(t_acc + 5));
    chk("t2_err", 32'(done_err), 0);
    chk("t2_ready_in_done", 32'(done_rdy), 0);
    obs_q = adr_q;
    exp_q.push_back(32'h40); exp_q.push_back(32'h44); exp_q.push_back(32'h48); exp_q.push_back(32'h4C);
    drain("t2_adr");
    obs_q = cti_q;
    exp_q.push_back(32'h2); exp_q.push_back(32'h2); exp_q.push_back(32'h2); exp_q.push_back(32'h7);
    drain("t2_cti");
    obs_q = rd_q;
    exp_q.push_back(32'h11); exp_q.push_back(32'h22); exp_q.push_back(32'h33); exp_q.push_back(32'h44);
    drain("t2_rd");
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'(t_acc + 2 + i));
      obs_q[i] = 32'(rdcyc_q.size() > i ? rdcyc_q[i] : -1);
    end
    obs_q = obs_q[0:3];
    drain("t2_rd_cycle");
    @(negedge clk);
    chk("t2_ready_after_done", 32'(cmd_ready), 1);

    // Wrap-4 write of 0xA0..0xA3 from 0x18.
    clear_mon();
    fork
      feed(4, 32'hA0, -1, 0);
      begin
        issue(32'h18, 8'd3, 1'b1, 2'b01);
        wait_done("t3");
      end
    join
    chk("t3_err", 32'(done_err), 0);
    obs_q = adr_q;
    exp_q.push_back(32'h18); exp_q.push_back(32'h1C); exp_q.push_back(32'h10); exp_q.push_back(32'h14);
    drain("t3_adr");
    obs_q = cti_q;
    exp_q.push_back(32'h2); exp_q.push_back(32'h2); exp_q.push_back(32'h2); exp_q.push_back(32'h7);
    drain("t3_cti");
    chk("t3_mem6", mem[6], 32'hA0);
    chk("t3_mem7", mem[7], 32'hA1);
    chk("t3_mem4", mem[4], 32'hA2);
    chk("t3_mem5", mem[5], 32'hA3);

    // 8-beat linear write from 0x80 with a 3-cycle data stall after beat 2.
    clear_mon();
    g0 = gap_cnt;
    fork
      feed(8, 32'hB0, 2, 3);
      begin
        issue(32'h80, 8'd7, 1'b1, 2'b00);
        wait_done("t4");
      end
    join
    chk("t4_err", 32'(done_err), 0);
    // One cycle while the holding register first fills, plus the three starved cycles.
    chk("t4_stb_low_cycles", 32'(gap_cnt - g0), 32'd4);
    obs_q = wdat_q;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'hB0 + 32'(i));
    drain("t4_wdat");
    obs_q = adr_q;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h80 + 32'(4 * i));
    drain("t4_adr");
    for (int i = 0; i < 8; i++) chk($sformatf("t4_mem[%0d]", i), mem[32 + i], 32'hB0 + 32'(i));

    // Bus error on beat 3 of an 8-beat read from 0x00.
    clear_mon();
    err_beat = 2;
    issue(32'h0, 8'd7, 1'b0, 2'b00);
    wait_done("t5");
    err_beat = 255;
    chk("t5_done_cycle", 32'(done_cyc), 32'(t_acc + 4));
    chk("t5_err", 32'(done_err), 1);
    chk("t5_cyc_in_done", 32'(done_cyc_o), 0);
    chk("t5_ready_in_done", 32'(done_rdy), 0);
    obs_q = rd_q;
    exp_q.push_back(32'hC0DE0000); exp_q.push_back(32'hC0DE0001);
    drain("t5_rd");
    @(negedge clk);
    chk("t5_ready_after_done", 32'(cmd_ready), 1);
    chk("t5_err_cleared", 32'(err), 0);

    // Reset while beat 2 of a 16-beat read is on the bus.
    clear_mon();
    issue(32'h0, 8'd15, 1'b0, 2'b00);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("t6_busy_before_rst", 32'(wb.wb_cyc_o), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_cyc", 32'(wb.wb_cyc_o), 0);
    chk("t6_stb", 32'(wb.wb_stb_o), 0);
    chk("t6_adr", wb.wb_adr_o, 0);
    chk("t6_cti", 32'(wb.wb_cti_o), 0);
    chk("t6_bte", 32'(wb.wb_bte_o), 0);
    chk("t6_we", 32'(wb.wb_we_o), 0);
    chk("t6_dat", wb.wb_dat_o, 0);
    chk("t6_rd_valid", 32'(rd_valid), 0);
    chk("t6_rd_data", rd_data, 0);
    chk("t6_done", 32'(done), 0);
    chk("t6_err", 32'(err), 0);
    chk("t6_wr_ready", 32'(wr_ready), 0);
    chk("t6_cmd_ready", 32'(cmd_ready), 1);
    chk("t6_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    dsum = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dsum += int'(done);
    end
    chk("t6_no_done", 32'(dsum), 0);

    // Fresh 2-beat read after the reset.
    clear_mon();
    issue(32'h40, 8'd1, 1'b0, 2'b00);
    wait_done("t7");
    chk("t7_done_cycle", 32'(done_cyc), 32'(t_acc + 3));
    chk("t7_err", 32'(done_err), 0);
    obs_q = rd_q; exp_q.push_back(32'h11); exp_q.push_back(32'h22); drain("t7_rd");
    obs_q = cti_q; exp_q.push_back(32'h2); exp_q.push_back(32'h7); drain("t7_cti");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
